// File: rtl/dram_arbiter.sv
// Data-RAM arbiter sharing one RAM port between the MA stage, a DMA engine and a
// debug monitor, with a starvation guard that steals a CPU cycle for external requesters.
module dram_arbiter #(
  parameter int DWIDTH     = 11,
  parameter int STARVE_MAX = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  // MA stage
  input  logic                                 cpu_req,
  input  logic [3:0]                           cpu_we,
  input  logic [DWIDTH-1:0]                    cpu_adr,
  input  logic [31:0]                          cpu_wdata,
  output logic                                 cpu_gnt,
  output logic                                 stall_req,
  // DMA
  input  logic                                 dma_req,
  input  logic                                 dma_we,
  input  logic [13:0]                          dma_adr,
  input  logic [15:0]                          dma_wdata,
  output logic                                 dma_gnt,
  output logic                                 dma_rvalid,
  output logic [15:0]                          dma_rdata,
  // debug monitor
  input  logic                                 dbg_req,
  input  logic                                 dbg_we,
  input  logic [DWIDTH-1:0]                    dbg_adr,
  input  logic [31:0]                          dbg_wdata,
  output logic                                 dbg_gnt,
  output logic                                 dbg_rvalid,
  output logic [31:0]                          dbg_rdata,
  // RAM
  output logic [DWIDTH-1:0]                    ram_radr,
  output logic [DWIDTH-1:0]                    ram_wadr,
  output logic [31:0]                          ram_wdata,
  output logic [3:0]                           ram_wen,
  input  logic [31:0]                          ram_rdata,
  // state observation
  output logic                                 fsm_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]      starve_count
);

  // Handshake: a requester raises req with its payload and holds both unchanged
  // until it sees its gnt high in the same cycle; the access happens in that cycle.
  // Read data returns one cycle later with rvalid, which has no back-pressure.

  localparam int CW = $clog2(STARVE_MAX+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  localparam logic [0:0] S_NORMAL = 1'b0;
  localparam logic [0:0] S_FORCE  = 1'b1;

  localparam logic EXT_DMA = 1'b0;
  localparam logic EXT_DBG = 1'b1;

  logic [0:0]        state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic              last_ext;
  logic              rst_d;
  logic              dma_rv_q, dbg_rv_q;

  logic              blocked;
  logic              ext_pend;
  logic              pick_dma, pick_dbg;
  logic [DWIDTH-1:0] dma_adr_ext;
  logic              unused_dma_adr;

  assign unused_dma_adr = ^dma_adr;

  always_comb begin
    dma_adr_ext = '0;
    for (int i = 0; i < DWIDTH && i < 14; i++) dma_adr_ext[i] = dma_adr[i];
  end

  // Grants are suppressed while in reset and for the first cycle after it.
  assign blocked  = rst | rst_d;
  assign ext_pend = dma_req | dbg_req;
  assign pick_dma = dma_req & (~dbg_req | (last_ext == EXT_DBG));
  assign pick_dbg = dbg_req & ~pick_dma;

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    stall_req = 1'b0;
    if (!blocked) begin
      if (state == S_FORCE) begin
        stall_req = 1'b1;
        dma_gnt   = pick_dma;
        dbg_gnt   = pick_dbg;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else begin
        dma_gnt = pick_dma;
        dbg_gnt = pick_dbg;
      end
    end
  end

  always_comb begin
    ram_radr  = '0;
    ram_wadr  = '0;
    ram_wdata = '0;
    ram_wen   = '0;
    if (cpu_gnt) begin
      ram_radr  = cpu_adr;
      ram_wadr  = cpu_adr;
      ram_wdata = cpu_wdata;
      ram_wen   = cpu_we;
    end else if (dma_gnt) begin
      ram_radr  = dma_adr_ext;
      ram_wadr  = dma_adr_ext;
      ram_wdata = {16'd0, dma_wdata};
      ram_wen   = {4{dma_we}};
    end else if (dbg_gnt) begin
      ram_radr  = dbg_adr;
      ram_wadr  = dbg_adr;
      ram_wdata = dbg_wdata;
      ram_wen   = {4{dbg_we}};
    end
  end

  always_comb begin
    cnt_next   = cnt;
    state_next = state;
    if (!blocked) begin
      if (state == S_FORCE) begin
        cnt_next   = '0;
        state_next = S_NORMAL;
      end else begin
        if (cpu_gnt && ext_pend) begin
          cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end else begin
          cnt_next = '0;
        end
        if (cnt_next == CNT_MAX) state_next = S_FORCE;
      end
    end
  end

  always_ff @(posedge clk) begin
    rst_d <= rst;
    if (rst) begin
      state    <= S_NORMAL;
      cnt      <= '0;
      last_ext <= EXT_DBG;
      dma_rv_q <= 1'b0;
      dbg_rv_q <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      dma_rv_q <= dma_gnt & ~dma_we;
      dbg_rv_q <= dbg_gnt & ~dbg_we;
      if (dma_gnt)      last_ext <= EXT_DMA;
      else if (dbg_gnt) last_ext <= EXT_DBG;
    end
  end

  // A read accepted just before reset must not surface while reset is held.
  assign dma_rvalid   = dma_rv_q & ~rst;
  assign dbg_rvalid   = dbg_rv_q & ~rst;
  assign dma_rdata    = ram_rdata[15:0];
  assign dbg_rdata    = ram_rdata;
  assign fsm_state    = state[0];
  assign starve_count = cnt;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus randomized traffic checked against
// a cycle-level reference model of the arbitration rules and a shadow memory.
module tb_dram_arbiter;

  localparam int DW = 11;
  localparam int SM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [DW-1:0] cpu_adr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, stall_req;
  logic        dma_req, dma_we;
  logic [13:0] dma_adr;
  logic [15:0] dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [15:0] dma_rdata;
  logic        dbg_req, dbg_we;
  logic [DW-1:0] dbg_adr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [DW-1:0] ram_radr, ram_wadr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rdata;
  logic        fsm_state;
  logic [3:0]  starve_count;

  int n_checks = 0;
  int n_errors = 0;

  dram_arbiter #(.DWIDTH(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .stall_req(stall_req),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_radr(ram_radr), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .ram_rdata(ram_rdata), .fsm_state(fsm_state), .starve_count(starve_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // RAM behaviour: synchronous read, byte-enabled write
  logic [31:0] ram_mem [0:2047] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) ram_mem[ram_wadr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= ram_mem[ram_radr];
  end

  // reference model state
  logic [31:0] shadow [0:2047] = '{default: 32'h0};
  int   m_cnt      = 0;
  bit   m_force    = 0;
  bit   m_dma_next = 1;
  bit   m_blk      = 1;
  bit   m_rv_dma   = 0;
  bit   m_rv_dbg   = 0;
  logic [31:0] m_rd_exp = 32'h0;

  // 0 none, 1 cpu, 2 dma, 3 dbg
  function automatic int ext_pick();
    if (dma_req && dbg_req) return m_dma_next ? 2 : 3;
    if (dma_req) return 2;
    if (dbg_req) return 3;
    return 0;
  endfunction

  function automatic int exp_grant();
    if (rst || m_blk) return 0;
    if (m_force) return ext_pick();
    if (cpu_req) return 1;
    return ext_pick();
  endfunction

  task automatic model_edge(input int g);
    if (rst) begin
      m_cnt = 0; m_force = 0; m_dma_next = 1; m_blk = 1;
      m_rv_dma = 0; m_rv_dbg = 0;
    end else begin
      m_rv_dma = (g == 2) && !dma_we;
      m_rv_dbg = (g == 3) && !dbg_we;
      if (g == 1)
        for (int b = 0; b < 4; b++)
          if (cpu_we[b]) shadow[cpu_adr][8*b +: 8] = cpu_wdata[8*b +: 8];
      if (g == 2) begin
        if (dma_we) shadow[dma_adr[DW-1:0]] = {16'd0, dma_wdata};
        else m_rd_exp = shadow[dma_adr[DW-1:0]];
        m_dma_next = 0;
      end
      if (g == 3) begin
        if (dbg_we) shadow[dbg_adr] = dbg_wdata;
        else m_rd_exp = shadow[dbg_adr];
        m_dma_next = 1;
      end
      if (m_blk) m_blk = 0;
      else if (m_force) begin
        m_force = 0; m_cnt = 0;
      end else if (g == 1 && (dma_req || dbg_req)) begin
        m_cnt = (m_cnt < SM) ? m_cnt + 1 : SM;
        if (m_cnt == SM) m_force = 1;
      end else m_cnt = 0;
    end
  endtask

  // driver tasks
  task automatic set_idle();
    cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_adr = 0; dma_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_adr = 0; dbg_wdata = 0;
  endtask

  task automatic tick();
    int g;
    g = exp_grant();
    @(posedge clk);
    model_edge(g);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; set_idle();
    cpu_req = 1; dma_req = 1; dma_we = 1; dbg_req = 1;
    #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt, dbg_gnt, stall_req} !== 4'b0000 || ram_wen !== 4'h0) begin
      n_errors++; $display("FAIL reset_grants got %b wen %h exp 0000 wen 0", {cpu_gnt, dma_gnt, dbg_gnt, stall_req}, ram_wen);
    end
    tick();
    n_checks++;
    if ({fsm_state, dma_rvalid, dbg_rvalid} !== 3'b000 || starve_count !== 4'd0) begin
      n_errors++; $display("FAIL reset_state got %b cnt %0d exp 000 cnt 0", {fsm_state, dma_rvalid, dbg_rvalid}, starve_count);
    end
    rst = 0;
    #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt, dbg_gnt, stall_req} !== 4'b0000 || ram_wen !== 4'h0) begin
      n_errors++; $display("FAIL reset_release_cycle got %b wen %h exp 0000 wen 0", {cpu_gnt, dma_gnt, dbg_gnt, stall_req}, ram_wen);
    end
    tick();
    #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt, dbg_gnt} !== 3'b100) begin
      n_errors++; $display("FAIL post_reset_cpu got %b exp 100", {cpu_gnt, dma_gnt, dbg_gnt});
    end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_dma_write_read();
    set_idle();
    dma_req = 1; dma_we = 1; dma_adr = 14'h0010; dma_wdata = 16'hBEEF;
    #1;
    n_checks++;
    if (dma_gnt !== 1'b1 || ram_wen !== 4'b1111 || ram_wdata !== 32'h0000BEEF || ram_wadr !== 11'h010) begin
      n_errors++; $display("FAIL dma_write got gnt %b wen %b wdata %h adr %h exp 1 1111 0000beef 010", dma_gnt, ram_wen, ram_wdata, ram_wadr);
    end
    tick();
    dma_we = 0;
    #1;
    n_checks++;
    if (dma_gnt !== 1'b1 || ram_wen !== 4'b0000 || ram_radr !== 11'h010) begin
      n_errors++; $display("FAIL dma_read_issue got gnt %b wen %b adr %h exp 1 0000 010", dma_gnt, ram_wen, ram_radr);
    end
    tick();
    set_idle();
    #1;
    n_checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 16'hBEEF) begin
      n_errors++; $display("FAIL dma_read_data got v %b d %h exp 1 beef", dma_rvalid, dma_rdata);
    end
    tick();
    #1;
    n_checks++;
    if (dma_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL dma_rvalid_single got %b exp 0", dma_rvalid);
    end
  endtask

  task automatic test_tie();
    logic [1:0] seq [4];
    seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b01;
    do_reset();
    dma_req = 1; dma_we = 1; dma_adr = 14'h5; dma_wdata = 16'h1234;
    dbg_req = 1; dbg_we = 1; dbg_adr = 11'h6; dbg_wdata = 32'h5678_9abc;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if ({cpu_gnt, dma_gnt, dbg_gnt} !== {1'b0, seq[c]}) begin
        n_errors++; $display("FAIL tie_cycle%0d got %b exp 0%b", c, {cpu_gnt, dma_gnt, dbg_gnt}, seq[c]);
      end
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_starve();
    do_reset();
    cpu_req = 1; cpu_adr = 11'h40;
    dbg_req = 1; dbg_we = 1; dbg_adr = 11'h41; dbg_wdata = 32'hCAFE_0001;
    for (int c = 1; c <= 10; c++) begin
      #1;
      n_checks++;
      if (c == 9) begin
        if ({cpu_gnt, dbg_gnt, stall_req, fsm_state} !== 4'b0111 || starve_count !== 4'd8) begin
          n_errors++; $display("FAIL starve_force got %b cnt %0d exp 0111 cnt 8", {cpu_gnt, dbg_gnt, stall_req, fsm_state}, starve_count);
        end
      end else begin
        if ({cpu_gnt, dbg_gnt, stall_req} !== 3'b100) begin
          n_errors++; $display("FAIL starve_cycle%0d got %b exp 100", c, {cpu_gnt, dbg_gnt, stall_req});
        end
      end
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_cpu_store();
    do_reset();
    cpu_req = 1; cpu_we = 4'b0100; cpu_wdata = 32'h00AB_0000; cpu_adr = 11'h20;
    dma_req = 1; dma_adr = 14'h21;
    #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10 || ram_wen !== 4'b0100 || ram_wdata !== 32'h00AB_0000) begin
      n_errors++; $display("FAIL cpu_store got %b wen %b wdata %h exp 10 0100 00ab0000", {cpu_gnt, dma_gnt}, ram_wen, ram_wdata);
    end
    tick();
    set_idle();
    #1;
    n_checks++;
    if (starve_count !== 4'd1) begin
      n_errors++; $display("FAIL cpu_store_count got %0d exp 1", starve_count);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    dbg_req = 1; dbg_we = 0; dbg_adr = 11'h41;
    #1;
    n_checks++;
    if (dbg_gnt !== 1'b1) begin
      n_errors++; $display("FAIL midread_gnt got %b exp 1", dbg_gnt);
    end
    tick();
    set_idle(); rst = 1;
    #1;
    n_checks++;
    if (dbg_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL midread_rvalid got %b exp 0", dbg_rvalid);
    end
    tick();
    rst = 0;
    tick();
    dma_req = 1; dbg_req = 1; dma_we = 1; dbg_we = 1;
    #1;
    n_checks++;
    if ({dma_gnt, dbg_gnt} !== 2'b10) begin
      n_errors++; $display("FAIL midread_first_tie got %b exp 10", {dma_gnt, dbg_gnt});
    end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_idle_force();
    do_reset();
    cpu_req = 1; dbg_req = 1; dbg_we = 1;
    for (int c = 1; c <= 8; c++) tick();
    dbg_req = 0;
    #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt, dbg_gnt, stall_req} !== 4'b0001 || ram_wen !== 4'h0) begin
      n_errors++; $display("FAIL idle_force got %b wen %h exp 0001 wen 0", {cpu_gnt, dma_gnt, dbg_gnt, stall_req}, ram_wen);
    end
    tick();
    #1;
    n_checks++;
    if ({cpu_gnt, stall_req, fsm_state} !== 3'b100) begin
      n_errors++; $display("FAIL idle_force_return got %b exp 100", {cpu_gnt, stall_req, fsm_state});
    end
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    dma_req = 1; dma_we = 0;
    for (int c = 0; c < 4; c++) begin
      dma_adr = 14'(c);
      #1;
      if (c > 0) begin
        n_checks++;
        if (dma_rvalid !== 1'b1 || dma_gnt !== 1'b1 || dma_rdata !== shadow[c-1][15:0]) begin
          n_errors++; $display("FAIL b2b_read%0d got v %b g %b d %h exp 1 1 %h", c, dma_rvalid, dma_gnt, dma_rdata, shadow[c-1][15:0]);
        end
      end
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    int g;
    bit cpu_hold, dma_hold, dbg_hold;
    logic [2:0] exp_vec;
    logic [3:0] exp_wen;
    logic [DW-1:0] exp_adr;
    logic [31:0] exp_wd;
    cpu_hold = 0; dma_hold = 0; dbg_hold = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!cpu_hold) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        cpu_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        cpu_adr = DW'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      if (!dma_hold) begin
        dma_req = ($urandom_range(0, 2) == 0);
        dma_we = $urandom_range(0, 1);
        dma_adr = 14'($urandom_range(0, 15));
        dma_wdata = 16'($urandom);
      end
      if (!dbg_hold) begin
        dbg_req = ($urandom_range(0, 2) == 0);
        dbg_we = $urandom_range(0, 1);
        dbg_adr = DW'($urandom_range(0, 15));
        dbg_wdata = $urandom;
      end
      #1;
      g = exp_grant();
      exp_vec = (g == 1) ? 3'b100 : (g == 2) ? 3'b010 : (g == 3) ? 3'b001 : 3'b000;
      exp_wen = (g == 1) ? cpu_we : (g == 2) ? {4{dma_we}} : (g == 3) ? {4{dbg_we}} : 4'h0;
      exp_adr = (g == 1) ? cpu_adr : (g == 2) ? dma_adr[DW-1:0] : dbg_adr;
      exp_wd = (g == 1) ? cpu_wdata : (g == 2) ? {16'd0, dma_wdata} : dbg_wdata;
      n_checks++;
      if ({cpu_gnt, dma_gnt, dbg_gnt} !== exp_vec || stall_req !== (!(rst || m_blk) && m_force)) begin
        n_errors++; $display("FAIL rnd_grant c%0d got %b s %b exp %b s %b", i, {cpu_gnt, dma_gnt, dbg_gnt}, stall_req, exp_vec, m_force);
      end
      n_checks++;
      if (ram_wen !== exp_wen) begin
        n_errors++; $display("FAIL rnd_wen c%0d got %b exp %b", i, ram_wen, exp_wen);
      end
      if (g != 0) begin
        n_checks++;
        if (ram_radr !== exp_adr || ram_wadr !== exp_adr || (exp_wen != 0 && ram_wdata !== exp_wd)) begin
          n_errors++; $display("FAIL rnd_port c%0d got %h %h %h exp %h %h", i, ram_radr, ram_wadr, ram_wdata, exp_adr, exp_wd);
        end
      end
      n_checks++;
      if (dma_rvalid !== (m_rv_dma && !rst) || dbg_rvalid !== (m_rv_dbg && !rst)) begin
        n_errors++; $display("FAIL rnd_rvalid c%0d got %b%b exp %b%b", i, dma_rvalid, dbg_rvalid, m_rv_dma && !rst, m_rv_dbg && !rst);
      end
      if (dma_rvalid && m_rv_dma) begin
        n_checks++;
        if (dma_rdata !== m_rd_exp[15:0]) begin
          n_errors++; $display("FAIL rnd_dma_rdata c%0d got %h exp %h", i, dma_rdata, m_rd_exp[15:0]);
        end
      end
      if (dbg_rvalid && m_rv_dbg) begin
        n_checks++;
        if (dbg_rdata !== m_rd_exp) begin
          n_errors++; $display("FAIL rnd_dbg_rdata c%0d got %h exp %h", i, dbg_rdata, m_rd_exp);
        end
      end
      n_checks++;
      if (starve_count !== 4'(m_cnt) || fsm_state !== m_force) begin
        n_errors++; $display("FAIL rnd_state c%0d got cnt %0d f %b exp cnt %0d f %b", i, starve_count, fsm_state, m_cnt, m_force);
      end
      cpu_hold = cpu_req && (g != 1) && !rst;
      dma_hold = dma_req && (g != 2) && !rst;
      dbg_hold = dbg_req && (g != 3) && !rst;
      tick();
    end
    rst = 0;
    set_idle();
    tick();
  endtask

  initial begin
    rst = 1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_dma_write_read();
    test_tie();
    test_starve();
    test_cpu_store();
    test_reset_mid_read();
    test_idle_force();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 11, which sets the data RAM word-address width as [DWIDTH+1:2].
REQ-002 SHALL have parameter STARVE_MAX, default 8, which sets the number of consecutive denied external-request cycles before a forced slot.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cpu_req  in  1  MA-stage load/store access this cycle.
REQ-006 cpu_we  in  4  MA-stage byte write enables; all zero means read.
REQ-007 cpu_adr  in  DWIDTH  MA-stage word address.
REQ-008 cpu_wdata  in  32  MA-stage store data, already byte-aligned.
REQ-009 cpu_gnt  out  1  MA access is performed this cycle.
REQ-010 stall_req  out  1  requests a pipeline stall; MA holds its request.
REQ-011 dma_req / dma_we  in  1 / 1  DMA access request and write flag.
REQ-012 dma_adr / dma_wdata  in  14 / 16  DMA word address [15:2] and write data.
REQ-013 dma_gnt / dma_rvalid  out  1 / 1  DMA accepted; DMA read data valid.
REQ-014 dma_rdata  out  16  DMA read data, ram_rdata[15:0].
REQ-015 dbg_req / dbg_we  in  1 / 1  debug-monitor request and write flag.
REQ-016 dbg_adr / dbg_wdata  in  DWIDTH / 32  debug word address and write data.
REQ-017 dbg_gnt / dbg_rvalid / dbg_rdata  out  1 / 1 / 32  debug accepted; debug read data valid; debug read data.
REQ-018 ram_radr / ram_wadr  out  DWIDTH / DWIDTH  RAM read and write addresses.
REQ-019 ram_wdata / ram_wen  out  32 / 4  RAM write data and byte write enables.
REQ-020 ram_rdata  in  32  RAM read data, valid one cycle after the address is presented.

Function
REQ-021 SHALL grant at most one of cpu_gnt, dma_gnt and dbg_gnt per cycle; grants are combinational in the request cycle.
REQ-022 SHALL operate in two states: NORMAL and FORCE.
REQ-023 In NORMAL, cpu_req SHALL win; otherwise, if external requesters are pending, the external requester is chosen by REQ-024.
REQ-024 DMA-vs-debug choice SHALL be round-robin: last_ext register; when both are pending, grant the one not granted last; a single pending requester is granted regardless of last_ext.
REQ-025 Starvation counter (saturating, width clog2(STARVE_MAX+1)):
- SHALL increment in NORMAL when cpu_gnt=1 and (dma_req|dbg_req)=1;
- SHALL clear on any external grant or when no external request is pending.
REQ-026 NORMAL->FORCE SHALL occur when the counter reaches STARVE_MAX.
REQ-027 In FORCE, the block SHALL assert stall_req=1, hold cpu_gnt=0, grant the external requester per REQ-024, clear the counter, and return to NORMAL the next cycle.
- If the external request has dropped, the FORCE cycle SHALL be an idle slot.
REQ-028 The granted requester SHALL drive the RAM ports:
- ram_radr = granted address;
- ram_wadr = granted address;
- ram_wen = cpu_we, or 4'b1111 for a DMA/debug write, or 0 for a read or no grant.
REQ-029 DMA write data SHALL be zero-extended: ram_wdata = {16'd0, dma_wdata}.
REQ-030 dma_rvalid and dbg_rvalid SHALL be registered, asserting exactly one cycle after a granted read; the matching rdata is ram_rdata in that cycle.
REQ-031 Simultaneous last-cycle DMA rvalid and a new DMA grant SHALL both be honoured, giving back-to-back reads at 1/cycle.
REQ-032 Ungranted requesters SHALL hold their request; the arbiter stores no request payload.

Reset
REQ-033 On rst=1 at a clock edge: state=NORMAL, counter=0, last_ext=debug (DMA wins the first tie), dma_rvalid=0, dbg_rvalid=0.
REQ-034 During rst=1 and in the cycle it deasserts, all grants, stall_req and ram_wen SHALL be 0.
REQ-035 A read granted in the cycle before reset asserts SHALL NOT produce rvalid.

Verification
REQ-036 DMA write then read: dma_req=1, dma_we=1, adr=0x0010, wdata=0xBEEF with no contention -> dma_gnt same cycle, ram_wen=1111, ram_wdata=0x0000BEEF; read of the same address -> dma_rvalid next cycle, dma_rdata=0xBEEF.
REQ-037 Tie: dma_req and dbg_req held for 4 cycles, cpu idle -> grants DMA, DBG, DMA, DBG.
REQ-038 Starvation: cpu_req and dbg_req held continuously with STARVE_MAX=8 -> cpu_gnt for cycles 1-8, cycle 9 stall_req=1 and dbg_gnt=1, cycle 10 cpu_gnt=1.
REQ-039 CPU byte store: cpu_we=0100, cpu_wdata=0x00AB0000, with dma_req also asserted -> cpu_gnt=1, dma_gnt=0, ram_wen=0100, counter=1.
REQ-040 Reset mid-read: dbg read granted in cycle N, rst=1 in cycle N+1 -> dbg_rvalid=0 in cycle N+1, and the first tie after reset goes to DMA.
REQ-041 Idle FORCE: the counter reaches 8 and dbg_req drops in the same cycle -> one cycle with stall_req=1 and no grant, then NORMAL.
